// File: rtl/mic_frame_aligner_if.sv
// Purpose: sample-side and frame-side signal bundle of the microphone frame aligner.
// Latency: none, wires only.
// Backpressure: frame_ready_in stalls the frame side; the sample side has none, so full FIFOs drop and flag.
//
// Ports and modports:
//   master - drives valid_in/data_in/frame_ready_in/clear_in and observes the frame outputs
//   slave  - the aligner: consumes samples, produces frames, overflow flags and the timeout pulse
interface mic_frame_aligner_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 3
);

  logic [NUM_CH-1:0]            valid_in;
  logic [NUM_CH*DATA_WIDTH-1:0] data_in;
  logic                         frame_ready_in;
  logic                         clear_in;
  logic                         frame_valid_out;
  logic [NUM_CH*DATA_WIDTH-1:0] frame_data_out;
  logic [NUM_CH-1:0]            overflow_out;
  logic                         timeout_out;

  modport master (
    output valid_in,
    output data_in,
    output frame_ready_in,
    output clear_in,
    input  frame_valid_out,
    input  frame_data_out,
    input  overflow_out,
    input  timeout_out
  );

  modport slave (
    input  valid_in,
    input  data_in,
    input  frame_ready_in,
    input  clear_in,
    output frame_valid_out,
    output frame_data_out,
    output overflow_out,
    output timeout_out
  );

endinterface

// File: rtl/mic_frame_aligner.sv
// Purpose: buffer per-mic samples and release time-aligned multi-channel frames; flush orphans on timeout.
// Latency: 2 cycles from the last channel's valid_in to frame_valid_out when the output register is free.
// Backpressure: frame_ready_in low holds the frame; FIFOs absorb FIFO_DEPTH more, then samples drop (sticky overflow).
//
// Ports:
//   clk_in, rst_n_in     - audio clock, asynchronous active-low reset
//   bus (slave modport)  - valid_in/data_in per channel, frame_ready_in, clear_in,
//                          frame_valid_out/frame_data_out, overflow_out, timeout_out
module mic_frame_aligner #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_CH         = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  mic_frame_aligner_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int FW = NUM_CH * DATA_WIDTH;

  // IDLE: every FIFO empty. PARTIAL: some but not all hold a sample.
  // COMPLETE: every FIFO holds at least one sample.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PARTIAL  = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  // Per-channel FIFO storage and pointers. Pointers carry one extra bit so
  // full and empty are distinguishable without a separate count.
  logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d    [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q [NUM_CH];
  logic [PW-1:0]         wr_ptr_d [NUM_CH];
  logic [PW-1:0]         rd_ptr_q [NUM_CH];
  logic [PW-1:0]         rd_ptr_d [NUM_CH];

  state_e                state_q;
  state_e                state_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;

  logic                  frame_valid_q;
  logic                  frame_valid_d;
  logic [FW-1:0]         frame_data_q;
  logic [FW-1:0]         frame_data_d;
  logic [NUM_CH-1:0]     overflow_q;
  logic [NUM_CH-1:0]     overflow_d;
  logic                  timeout_q;
  logic                  timeout_d;

  logic [NUM_CH-1:0]     empty;
  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     pop;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     drop;
  logic [NUM_CH-1:0]     empty_nxt;
  logic                  load;
  logic                  flush;

  // ---------------------------------------------------------------------------
  // Current FIFO occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    empty = '0;
    full  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
      full[k]  = ((wr_ptr_q[k] - rd_ptr_q[k]) == PW'(FIFO_DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment decisions. state_q always mirrors the occupancy seen this cycle,
  // so load and flush are mutually exclusive by construction.
  // ---------------------------------------------------------------------------
  always_comb begin
    load  = 1'b0;
    flush = 1'b0;
    case (state_q)
      ST_PARTIAL:  flush = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
      ST_COMPLETE: load  = ~frame_valid_q | bus.frame_ready_in;
      default:     ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO update. Pops are decided from the current contents before any write,
  // so a sample arriving during a flush lands behind the popped entry and
  // survives; a full FIFO that is popped this cycle still accepts a write.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pop        = '0;
    push       = '0;
    drop       = '0;
    empty_nxt  = '0;
    // Clearing first lets a drop in the same cycle re-set the flag.
    overflow_d = bus.clear_in ? '0 : overflow_q;
    for (int k = 0; k < NUM_CH; k++) begin
      pop[k]  = load | (flush & ~empty[k]);
      push[k] = bus.valid_in[k] & (~full[k] | pop[k]);
      drop[k] = bus.valid_in[k] & full[k] & ~pop[k];
      if (pop[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
      end
      if (push[k]) begin
        mem_d[k][wr_ptr_q[k][AW-1:0]] = bus.data_in[k*DATA_WIDTH +: DATA_WIDTH];
        wr_ptr_d[k] = wr_ptr_q[k] + 1'b1;
      end
      if (drop[k]) begin
        overflow_d[k] = 1'b1;
      end
      empty_nxt[k] = (wr_ptr_d[k] == rd_ptr_d[k]);
    end
  end

  // ---------------------------------------------------------------------------
  // Next state follows next-cycle occupancy.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = ST_PARTIAL;
    if (&empty_nxt) begin
      state_d = ST_IDLE;
    end else if (~|empty_nxt) begin
      state_d = ST_COMPLETE;
    end
  end

  // The counter only runs while staying in PARTIAL. Any entry into PARTIAL
  // (from IDLE, from COMPLETE after a load, or after a flush that leaves some
  // channels occupied) therefore starts from zero.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_PARTIAL) && (state_d == ST_PARTIAL) && !flush) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: one held frame, refilled in the same cycle it is taken.
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    if (frame_valid_q && bus.frame_ready_in) begin
      frame_valid_d = 1'b0;
    end
    if (load) begin
      frame_valid_d = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        frame_data_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][rd_ptr_q[k][AW-1:0]];
      end
    end
    timeout_d = flush;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem_q[k][e] <= '0;
        end
      end
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      overflow_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem_q[k][e] <= mem_d[k][e];
        end
      end
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      overflow_q    <= overflow_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.frame_valid_out = frame_valid_q;
  assign bus.frame_data_out  = frame_data_q;
  assign bus.overflow_out    = overflow_q;
  assign bus.timeout_out     = timeout_q;

  // ---------------------------------------------------------------------------
  // Internal consistency properties
  // ---------------------------------------------------------------------------
  // The registered state is a summary of occupancy and must never drift from it.
  a_idle_matches: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (state_q == ST_IDLE) == (&empty));
  a_complete_matches: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (state_q == ST_COMPLETE) == (~|empty));
  // A stalled frame stays put until the consumer takes it.
  a_hold_stable: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (frame_valid_q && !bus.frame_ready_in) |=> (frame_valid_q && $stable(frame_data_q)));

endmodule

// File: tb/tb_mic_frame_aligner.sv
// Purpose: self-checking bench for mic_frame_aligner using a queue-based reference model.
// Latency: n/a.
// Backpressure: frame_ready_in is driven directly by the scenarios.
module tb_mic_frame_aligner;

  localparam int DW = 16;
  localparam int NC = 3;
  localparam int FD = 4;
  localparam int TO = 4096;
  localparam int FW = NC * DW;

  logic clk_in;
  logic rst_n_in;
  int   n_cmp;
  int   n_bad;
  int   cyc = 0;

  mic_frame_aligner_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

  mic_frame_aligner #(
    .DATA_WIDTH    (DW),
    .NUM_CH        (NC),
    .FIFO_DEPTH    (FD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model: one queue per mic, a held frame, and the age of the
  // current partial frame in cycles.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mq [NC][$];
  logic          m_fv;
  logic [FW-1:0] m_fd;
  logic [NC-1:0] m_ovf;
  logic          m_to;
  int            m_age;

  task automatic model_reset();
    for (int k = 0; k < NC; k++) mq[k].delete();
    m_fv  = 1'b0;
    m_fd  = '0;
    m_ovf = '0;
    m_to  = 1'b0;
    m_age = 0;
  endtask

  // Advance the model by one clock edge using the inputs now on the bus.
  task automatic model_step();
    int   nz;
    logic ld;
    logic fl;
    logic pk;
    logic was_full;
    nz = 0;
    for (int k = 0; k < NC; k++) if (mq[k].size() != 0) nz++;
    ld = (nz == NC) && (!m_fv || bus.frame_ready_in);
    fl = (nz != 0) && (nz != NC) && (m_age == TO - 1);
    if (m_fv && bus.frame_ready_in) m_fv = 1'b0;
    if (ld) begin
      m_fv = 1'b1;
      for (int k = 0; k < NC; k++) m_fd[k*DW +: DW] = mq[k][0];
    end
    if (bus.clear_in) m_ovf = '0;
    for (int k = 0; k < NC; k++) begin
      was_full = (mq[k].size() == FD);
      pk = ld || (fl && mq[k].size() != 0);
      if (pk) void'(mq[k].pop_front());
      if (bus.valid_in[k]) begin
        if (!was_full || pk) mq[k].push_back(bus.data_in[k*DW +: DW]);
        else m_ovf[k] = 1'b1;
      end
    end
    m_to = fl;
    if (nz != 0 && nz != NC && !fl) m_age++;
    else m_age = 0;
  endtask

  // Drive one cycle of samples (from a negedge), step the model, land on the next negedge.
  task automatic tick(input logic [NC-1:0] v, input logic [FW-1:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
    model_step();
    @(negedge clk_in);
    bus.valid_in = '0;
  endtask

  task automatic do_reset();
    rst_n_in           = 1'b0;
    bus.valid_in       = '0;
    bus.data_in        = '0;
    bus.frame_ready_in = 1'b1;
    bus.clear_in       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  function automatic logic [FW-1:0] rnd_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[FW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n_in           = 1'b0;
    bus.valid_in       = '0;
    bus.data_in        = '0;
    bus.frame_ready_in = 1'b1;
    bus.clear_in       = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if ({bus.frame_valid_out, bus.timeout_out} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_valid_timeout: got %b expected 00", {bus.frame_valid_out, bus.timeout_out});
    end
    n_cmp++;
    if (bus.frame_data_out !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected 0", bus.frame_data_out);
    end
    n_cmp++;
    if (bus.overflow_out !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_overflow: got %b expected 000", bus.overflow_out);
    end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    repeat (3) begin
      tick('0, '0);
      n_cmp++;
      if (bus.frame_valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle_valid: got %b expected 0", bus.frame_valid_out);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    tick(3'b111, 48'h3333_2222_1111);
    n_cmp++;
    if (bus.frame_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_t1_valid: got %b expected 0", bus.frame_valid_out);
    end
    tick('0, '0);
    n_cmp++;
    if (bus.frame_valid_out !== 1'b1 || bus.frame_data_out !== 48'h3333_2222_1111) begin
      n_bad++;
      $display("FAIL basic_t2_frame: got v=%b d=%h expected v=1 d=333322221111",
               bus.frame_valid_out, bus.frame_data_out);
    end
    tick('0, '0);
    n_cmp++;
    if (bus.frame_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_t3_valid: got %b expected 0", bus.frame_valid_out);
    end
  endtask

  task automatic test_staggered();
    int            t;
    int            cur;
    logic [FW-1:0] d;
    logic [NC-1:0] v;
    do_reset();
    d = rnd_frame();
    t = cyc;
    tick(3'b001, d);
    for (int i = 1; i <= 505; i++) begin
      v = (i == 100) ? 3'b010 : (i == 500) ? 3'b100 : 3'b000;
      tick(v, d);
      cur = cyc;
      n_cmp++;
      if ({bus.frame_valid_out, bus.timeout_out} !== {(cur == t + 502), 1'b0}) begin
        n_bad++;
        $display("FAIL staggered_cycle%0d: got v=%b to=%b expected v=%b to=0",
                 cur - t, bus.frame_valid_out, bus.timeout_out, (cur == t + 502));
      end
      if (cur == t + 502) begin
        n_cmp++;
        if (bus.frame_data_out !== d) begin
          n_bad++;
          $display("FAIL staggered_data: got %h expected %h", bus.frame_data_out, d);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] fr [1:6];
    do_reset();
    bus.frame_ready_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      fr[i] = rnd_frame();
      tick(3'b111, fr[i]);
    end
    tick('0, '0);
    n_cmp++;
    if (bus.overflow_out !== 3'b111 || bus.frame_valid_out !== 1'b1 || bus.frame_data_out !== fr[1]) begin
      n_bad++;
      $display("FAIL bp_hold: got ovf=%b v=%b d=%h expected ovf=111 v=1 d=%h",
               bus.overflow_out, bus.frame_valid_out, bus.frame_data_out, fr[1]);
    end
    bus.frame_ready_in = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      tick('0, '0);
      n_cmp++;
      if (bus.frame_valid_out !== 1'b1 || bus.frame_data_out !== fr[i]) begin
        n_bad++;
        $display("FAIL bp_frame%0d: got v=%b d=%h expected v=1 d=%h",
                 i, bus.frame_valid_out, bus.frame_data_out, fr[i]);
      end
    end
    tick('0, '0);
    n_cmp++;
    if (bus.frame_valid_out !== 1'b0 || bus.overflow_out !== 3'b111) begin
      n_bad++;
      $display("FAIL bp_drained: got v=%b ovf=%b expected v=0 ovf=111",
               bus.frame_valid_out, bus.overflow_out);
    end
    bus.clear_in = 1'b1;
    tick('0, '0);
    bus.clear_in = 1'b0;
    n_cmp++;
    if (bus.overflow_out !== 3'b000) begin
      n_bad++;
      $display("FAIL bp_clear: got %b expected 000", bus.overflow_out);
    end
  endtask

  task automatic test_timeout();
    int            t;
    int            cur;
    logic [FW-1:0] d;
    do_reset();
    d = rnd_frame();
    t = cyc;
    tick(3'b011, d);
    for (int i = 1; i <= 4100; i++) begin
      tick('0, '0);
      cur = cyc;
      n_cmp++;
      if ({bus.frame_valid_out, bus.timeout_out} !== {1'b0, (cur == t + TO + 1)}) begin
        n_bad++;
        $display("FAIL timeout_cycle%0d: got v=%b to=%b expected v=0 to=%b",
                 cur - t, bus.frame_valid_out, bus.timeout_out, (cur == t + TO + 1));
      end
    end
    d = rnd_frame();
    tick(3'b111, d);
    tick('0, '0);
    n_cmp++;
    if (bus.frame_valid_out !== 1'b1 || bus.frame_data_out !== d) begin
      n_bad++;
      $display("FAIL timeout_after: got v=%b d=%h expected v=1 d=%h",
               bus.frame_valid_out, bus.frame_data_out, d);
    end
  endtask

  task automatic test_full_pop();
    logic [FW-1:0] fr [1:5];
    logic [DW-1:0] x;
    logic [FW-1:0] y;
    do_reset();
    bus.frame_ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      fr[i] = rnd_frame();
      tick(3'b111, fr[i]);
    end
    tick('0, '0);
    x = DW'($urandom());
    bus.frame_ready_in = 1'b1;
    tick(3'b001, {32'h0, x});
    n_cmp++;
    if (bus.overflow_out !== 3'b000 || bus.frame_data_out !== fr[2]) begin
      n_bad++;
      $display("FAIL fullpop_accept: got ovf=%b d=%h expected ovf=000 d=%h",
               bus.overflow_out, bus.frame_data_out, fr[2]);
    end
    for (int i = 3; i <= 5; i++) begin
      tick('0, '0);
      n_cmp++;
      if (bus.frame_valid_out !== 1'b1 || bus.frame_data_out !== fr[i]) begin
        n_bad++;
        $display("FAIL fullpop_frame%0d: got v=%b d=%h expected v=1 d=%h",
                 i, bus.frame_valid_out, bus.frame_data_out, fr[i]);
      end
    end
    tick('0, '0);
    y = rnd_frame();
    tick(3'b110, y);
    tick('0, '0);
    n_cmp++;
    if (bus.frame_valid_out !== 1'b1 || bus.frame_data_out !== {y[FW-1:DW], x} || bus.overflow_out !== 3'b000) begin
      n_bad++;
      $display("FAIL fullpop_late_frame: got v=%b d=%h ovf=%b expected v=1 d=%h ovf=000",
               bus.frame_valid_out, bus.frame_data_out, bus.overflow_out, {y[FW-1:DW], x});
    end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] d;
    do_reset();
    bus.frame_ready_in = 1'b0;
    repeat (3) tick(3'b111, rnd_frame());
    n_cmp++;
    if (bus.frame_valid_out !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pre: got v=%b expected 1", bus.frame_valid_out);
    end
    #2;
    rst_n_in = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.frame_valid_out, bus.frame_data_out, bus.overflow_out, bus.timeout_out} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_async: got v=%b d=%h ovf=%b to=%b expected all 0",
               bus.frame_valid_out, bus.frame_data_out, bus.overflow_out, bus.timeout_out);
    end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    bus.frame_ready_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick('0, '0);
      n_cmp++;
      if (bus.frame_valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_stale%0d: got v=%b expected 0", i, bus.frame_valid_out);
      end
    end
    d = rnd_frame();
    tick(3'b111, d);
    tick('0, '0);
    n_cmp++;
    if (bus.frame_valid_out !== 1'b1 || bus.frame_data_out !== d) begin
      n_bad++;
      $display("FAIL rstmid_fresh: got v=%b d=%h expected v=1 d=%h",
               bus.frame_valid_out, bus.frame_data_out, d);
    end
  endtask

  task automatic test_random();
    logic [NC-1:0] v;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < NC; k++) v[k] = ($urandom_range(0, 2) == 0);
      bus.frame_ready_in = ($urandom_range(0, 9) < 6);
      bus.clear_in       = ($urandom_range(0, 15) == 0);
      tick(v, rnd_frame());
      bus.clear_in = 1'b0;
      n_cmp++;
      if ({bus.frame_valid_out, bus.frame_data_out, bus.overflow_out, bus.timeout_out} !==
          {m_fv, m_fd, m_ovf, m_to}) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got v=%b d=%h ovf=%b to=%b expected v=%b d=%h ovf=%b to=%b",
                 i, bus.frame_valid_out, bus.frame_data_out, bus.overflow_out, bus.timeout_out,
                 m_fv, m_fd, m_ovf, m_to);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_staggered();
    test_backpressure();
    test_timeout();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
